// File: rtl/bound_flash_param.sv
// Bouncing LED-bar sequencer: one flick runs a fixed fill/drain pattern on a thermometer-coded bar.
// Optional BOUND_FLASH_LOOP_EN makes the pattern repeat until reset instead of returning to idle.
//
// state  | meaning
// IDLE   | bar dark, waiting for a start flick
// UP_TOP | fill to full; flick on a mark step kicks back
// DN_LO  | drain to the low mark
// UP_HI  | fill to the high mark
// DN_0   | drain to empty
// UP_LO  | fill to the low mark
// DN_END | final drain to empty
// KICK   | kickback drain to empty, then refill
module bound_flash_param #(
    parameter int N_LED    = 16,
    parameter int MARK_LO  = 5,
    parameter int MARK_HI  = 10,
    parameter int TICK_DIV = 1,
    parameter int LW       = $clog2(N_LED + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flick,
    output logic [3:0]       out_state,
    output logic [N_LED-1:0] out,
    output logic [LW-1:0]    level,
    output logic             busy
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TC_LAST = TW'(TICK_DIV - 1);
    localparam logic [LW-1:0] L_TOP   = LW'(N_LED);
    localparam logic [LW-1:0] L_LO    = LW'(MARK_LO);
    localparam logic [LW-1:0] L_HI    = LW'(MARK_HI);
    localparam logic [LW-1:0] L_ZERO  = '0;
    localparam logic [LW-1:0] L_ONE   = LW'(1);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        UP_TOP = 4'd1,
        DN_LO  = 4'd2,
        UP_HI  = 4'd3,
        DN_0   = 4'd4,
        UP_LO  = 4'd5,
        DN_END = 4'd6,
        KICK   = 4'd7
    } state_t;

    state_t           state, state_nx;
    logic [LW-1:0]    level_nx, lvl_up, lvl_dn;
    logic [TW-1:0]    tcnt, tcnt_nx;
    logic [N_LED-1:0] out_nx;
    logic             step;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            level <= '0;
            tcnt  <= '0;
            out   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            level <= level_nx;
            tcnt  <= tcnt_nx;
            out   <= out_nx;
            busy  <= (state_nx != IDLE);
        end
    end

    assign out_state = state;

    always_comb begin
        state_nx = state;
        level_nx = level;
        lvl_up   = level + L_ONE;
        lvl_dn   = level - L_ONE;
        step     = (tcnt == TC_LAST);
        tcnt_nx  = step ? '0 : tcnt + TW'(1);

        case (state)
            IDLE: begin
                tcnt_nx  = '0;
                level_nx = '0;
                if (flick) state_nx = UP_TOP;
            end
            UP_TOP: if (step) begin
                // Kickback replaces the increment on the mark step.
                if (flick && (level == L_LO || level == L_HI)) begin
                    state_nx = KICK;
                    level_nx = lvl_dn;
                end else begin
                    level_nx = lvl_up;
                    if (lvl_up == L_TOP) state_nx = DN_LO;
                end
            end
            DN_LO: if (step) begin
                level_nx = lvl_dn;
                if (lvl_dn == L_LO) state_nx = UP_HI;
            end
            UP_HI: if (step) begin
                level_nx = lvl_up;
                if (lvl_up == L_HI) state_nx = DN_0;
            end
            DN_0: if (step) begin
                level_nx = lvl_dn;
                if (lvl_dn == L_ZERO) state_nx = UP_LO;
            end
            UP_LO: if (step) begin
                level_nx = lvl_up;
                if (lvl_up == L_LO) state_nx = DN_END;
            end
            DN_END: if (step) begin
                level_nx = lvl_dn;
`ifdef BOUND_FLASH_LOOP_EN
                if (lvl_dn == L_ZERO) state_nx = UP_TOP;
`else
                if (lvl_dn == L_ZERO) state_nx = IDLE;
`endif
            end
            KICK: if (step) begin
                // A kick from level 1 lands on 0 already; just resume filling.
                if (level == L_ZERO) begin
                    state_nx = UP_TOP;
                end else begin
                    level_nx = lvl_dn;
                    if (lvl_dn == L_ZERO) state_nx = UP_TOP;
                end
            end
            default: begin
                state_nx = IDLE;
                level_nx = '0;
                tcnt_nx  = '0;
            end
        endcase

        out_nx = '0;
        for (int i = 0; i < N_LED; i++) out_nx[i] = (i < int'(level_nx));
    end

endmodule

// File: tb/tb_bound_flash_param.sv
// Bench for bound_flash_param: two instances (TICK_DIV 1 and 4) against a table-driven phase model.
module tb_bound_flash_param;

    localparam int N  = 16;
    localparam int LO = 5;
    localparam int HI = 10;
`ifdef BOUND_FLASH_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, flick;
    logic [3:0]    st1, st4;
    logic [N-1:0]  out1, out4;
    logic [4:0]    lvl1, lvl4;
    logic          busy1, busy4;

    typedef struct {
        int ph;
        int lvl;
        int tc;
    } mdl_t;

    mdl_t m1, m4;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    bound_flash_param #(.N_LED(N), .MARK_LO(LO), .MARK_HI(HI), .TICK_DIV(1)) dut (
        .clk(clk), .reset(reset), .flick(flick),
        .out_state(st1), .out(out1), .level(lvl1), .busy(busy1)
    );

    bound_flash_param #(.N_LED(N), .MARK_LO(LO), .MARK_HI(HI), .TICK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .flick(flick),
        .out_state(st4), .out(out4), .level(lvl4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Segment targets of the pattern; phase number equals the state code.
    function automatic int seg_tgt(input int ph);
        case (ph)
            1:       return N;
            2:       return LO;
            3:       return HI;
            5:       return LO;
            default: return 0;
        endcase
    endfunction

    function automatic mdl_t mdl_next(input mdl_t m, input bit fl, input bit rs, input int div);
        mdl_t n;
        n = m;
        if (rs) begin
            n.ph = 0; n.lvl = 0; n.tc = 0;
            return n;
        end
        if (m.ph == 0) begin
            n.tc = 0;
            if (fl) n.ph = 1;
            return n;
        end
        if (m.tc != div - 1) begin
            n.tc = m.tc + 1;
            return n;
        end
        n.tc = 0;
        if (m.ph == 1 && fl && (m.lvl == LO || m.lvl == HI)) begin
            n.ph  = 7;
            n.lvl = m.lvl - 1;
            return n;
        end
        if (m.ph == 7 && m.lvl == 0) begin
            n.ph = 1;
            return n;
        end
        n.lvl = m.lvl + ((m.ph == 1 || m.ph == 3 || m.ph == 5) ? 1 : -1);
        if (n.lvl == seg_tgt(m.ph))
            n.ph = (m.ph == 7) ? 1 : (m.ph == 6) ? (LOOP ? 1 : 0) : m.ph + 1;
        return n;
    endfunction

    task automatic cmp_all();
        chk("state1", 32'(st1),   32'(m1.ph));
        chk("out1",   32'(out1),  (32'(1) << m1.lvl) - 32'(1));
        chk("level1", 32'(lvl1),  32'(m1.lvl));
        chk("busy1",  32'(busy1), 32'(m1.ph != 0));
        chk("state4", 32'(st4),   32'(m4.ph));
        chk("out4",   32'(out4),  (32'(1) << m4.lvl) - 32'(1));
        chk("level4", 32'(lvl4),  32'(m4.lvl));
        chk("busy4",  32'(busy4), 32'(m4.ph != 0));
    endtask

    task automatic cyc(input bit f, input bit r);
        flick = f;
        reset = r;
        @(posedge clk);
        m1 = mdl_next(m1, f, r, 1);
        m4 = mdl_next(m4, f, r, 4);
        #1;
        cmp_all();
    endtask

    initial begin
        m1 = '{0, 0, 0};
        m4 = '{0, 0, 0};
        reset = 1'b1;
        flick = 1'b1;

        // Reset with flick held: no start.
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1);
            chk("rst_out", 32'(out1), 32'h0);
            chk("rst_state", 32'(st1), 32'h0);
            chk("rst_busy", 32'(busy1), 32'h0);
        end

        // Plain start, full pattern on both prescalers.
        cyc(1'b1, 1'b0);
        chk("start_state", 32'(st1), 32'd1);
        chk("start_out", 32'(out1), 32'h0);
        for (int k = 1; k <= 208; k++) begin
            cyc(1'b0, 1'b0);
            if (k == 1)  chk("first_lamp", 32'(out1), 32'h0001);
            if (k == 3)  chk("div4_dark", 32'(out4), 32'h0000);
            if (k == 4)  chk("div4_first", 32'(out4), 32'h0001);
            if (k == 16) chk("full_bar", 32'(out1), 32'hFFFF);
`ifdef BOUND_FLASH_LOOP_EN
            if (k == 52) begin
                chk("loop_state", 32'(st1), 32'd1);
                chk("loop_busy", 32'(busy1), 32'd1);
            end
            if (k == 68)  chk("loop_full", 32'(out1), 32'hFFFF);
            if (k == 208) chk("div4_loop", 32'(st4), 32'd1);
`else
            if (k == 51) chk("pre_end", 32'(st1), 32'd6);
            if (k == 52) begin
                chk("end_state", 32'(st1), 32'd0);
                chk("end_out", 32'(out1), 32'h0);
            end
            if (k == 207) chk("div4_pre_end", 32'(st4), 32'd6);
            if (k == 208) chk("div4_end", 32'(st4), 32'd0);
`endif
        end
        cyc(1'b0, 1'b1);

        // Kickback at the high mark, then stray flicks in later phases.
        cyc(1'b1, 1'b0);
        for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0);
        chk("at_hi", 32'(lvl1), 32'd10);
        cyc(1'b1, 1'b0);
        chk("kick_state", 32'(st1), 32'd7);
        chk("kick_out", 32'(out1), 32'h01FF);
        for (int k = 0; k < 9; k++) cyc(1'b0, 1'b0);
        chk("kick_done_state", 32'(st1), 32'd1);
        chk("kick_done_lvl", 32'(lvl1), 32'd0);
        cyc(1'b0, 1'b0);
        chk("refill", 32'(out1), 32'h0001);
        for (int k = 0; k < 51; k++) cyc((m1.ph != 1) && ($urandom_range(0, 1) == 1), 1'b0);
`ifndef BOUND_FLASH_LOOP_EN
        chk("kick_end", 32'(st1), 32'd0);
`endif
        cyc(1'b0, 1'b1);

        // Reset in the middle of UP_HI, then restart.
        cyc(1'b1, 1'b0);
        for (int k = 0; k < 29; k++) cyc(1'b0, 1'b0);
        chk("mid_state", 32'(st1), 32'd3);
        chk("mid_lvl", 32'(lvl1), 32'd7);
        cyc(1'b0, 1'b1);
        chk("mid_rst_out", 32'(out1), 32'h0);
        chk("mid_rst_state", 32'(st1), 32'd0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk("restart_state", 32'(st1), 32'd1);
        cyc(1'b0, 1'b0);
        chk("restart_lamp", 32'(out1), 32'h0001);

        // Random flicks and occasional resets.
        for (int k = 0; k < 4000; k++)
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
